// File: rtl/ws_pe_sat_if.sv
// Port bundle of one weight-stationary PE: weight chain, east-flowing activation,
// south-flowing partial sum, pause and saturation status.
interface ws_pe_sat_if #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 20
);
   logic              pause;
   logic [DATA_W-1:0] w_in;
   logic              w_load;
   logic [DATA_W-1:0] w_out;
   logic [DATA_W-1:0] in_a;
   logic              in_a_valid;
   logic [DATA_W-1:0] out_a;
   logic              out_a_valid;
   logic [ACC_W-1:0]  in_c;
   logic [ACC_W-1:0]  out_c;
   logic              out_c_valid;
   logic              sat_flag;
   logic              clr_sat;

   // Array controller / neighbouring cells drive the inputs of the PE.
   modport master (
      output pause, w_in, w_load, in_a, in_a_valid, in_c, clr_sat,
      input  w_out, out_a, out_a_valid, out_c, out_c_valid, sat_flag
   );

   modport slave (
      input  pause, w_in, w_load, in_a, in_a_valid, in_c, clr_sat,
      output w_out, out_a, out_a_valid, out_c, out_c_valid, sat_flag
   );
endinterface

// File: rtl/ws_pe_sat.sv
// Weight-stationary systolic PE: holds a preloaded weight, multiplies the east-flowing
// activation and adds it to the south-flowing partial sum with saturation.
module ws_pe_sat #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 20
) (
   input  logic        clk,
   input  logic        reset,
   ws_pe_sat_if.slave  bus
);
   localparam int EXT_W = ACC_W + 1 - 2 * DATA_W;
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   if (ACC_W < 2 * DATA_W) begin : g_width_check
      $error("ws_pe_sat: ACC_W must be at least 2*DATA_W");
   end

   logic [DATA_W-1:0]   w_reg;
   logic [DATA_W-1:0]   a_q;
   logic                a_valid_q;
   logic [ACC_W-1:0]    c_q;
   logic                c_valid_q;
   logic                sat_q;

   logic [2*DATA_W-1:0] a_ext;
   logic [2*DATA_W-1:0] w_ext;
   logic [2*DATA_W-1:0] prod;
   logic [ACC_W:0]      sum;
   logic                clip;
   logic [ACC_W-1:0]    sat_sum;

   // Sign-extended operands make the unsigned multiply/add produce exact two's-complement results.
   always_comb begin
      // NOTE: every combinational output gets a value on every path, so no latch is inferred.
      a_ext   = {{DATA_W{bus.in_a[DATA_W-1]}}, bus.in_a};
      w_ext   = {{DATA_W{w_reg[DATA_W-1]}}, w_reg};
      prod    = a_ext * w_ext;
      sum     = {bus.in_c[ACC_W-1], bus.in_c} + {{EXT_W{prod[2*DATA_W-1]}}, prod};
      clip    = sum[ACC_W] ^ sum[ACC_W-1];
      sat_sum = sum[ACC_W-1:0];
      if (clip) begin
         sat_sum = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         w_reg     <= '0;
         a_q       <= '0;
         a_valid_q <= 1'b0;
         c_q       <= '0;
         c_valid_q <= 1'b0;
         sat_q     <= 1'b0;
      end else if (!bus.pause) begin
         // The product above already used the old weight; a new weight applies from the next edge.
         if (bus.w_load) begin
            w_reg <= bus.w_in;
         end
         a_q       <= bus.in_a;
         a_valid_q <= bus.in_a_valid;
         if (bus.in_a_valid) begin
            c_q       <= sat_sum;
            c_valid_q <= 1'b1;
         end else begin
            c_q       <= bus.in_c;
            c_valid_q <= 1'b0;
         end
         if (bus.in_a_valid && clip) begin
            sat_q <= 1'b1;
         end else if (bus.clr_sat) begin
            sat_q <= 1'b0;
         end
      end
   end

   assign bus.w_out       = w_reg;
   assign bus.out_a       = a_q;
   assign bus.out_a_valid = a_valid_q;
   assign bus.out_c       = c_q;
   assign bus.out_c_valid = c_valid_q;
   assign bus.sat_flag    = sat_q;
endmodule
